vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates VGA raster timing for the display path: horizontal/vertical pixel counters, active-low sync pulses, a visible-area flag, and line/frame start strobes. It drives the `hcount`/`vcount` inputs of the downstream pixel-position stage, which clips them to the 640x480 visible area. It also drives the sync pins of the VGA connector. Default parameters give 640x480 @ 60 Hz from a 50 MHz board clock, using a divide-by-2 pixel enable.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `CLK_DIV`, 2, clk cycles per pixel; legal values ≥ 1
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `pix_en`  out  1  one-clk pixel enable, asserted every `CLK_DIV` clks
- `hcount`  out  10  horizontal position, 0..H_TOTAL-1
- `vcount`  out  10  vertical position, 0..V_TOTAL-1
- `hsync`  out  1  active-low horizontal sync
- `vsync`  out  1  active-low vertical sync
- `video_on`  out  1  high when (hcount,vcount) is in the visible area
- `line_start`  out  1  one-clk strobe when hcount becomes 0
- `frame_start`  out  1  one-clk strobe when hcount and vcount both become 0

## Operation
- H_TOTAL = sum of the H params (800); V_TOTAL = sum of the V params (525). Elaboration fails if either total exceeds 1024.
- Divider counter `div` runs 0..CLK_DIV-1. `pix_en` = (div == CLK_DIV-1), registered. When CLK_DIV = 1, `pix_en` is constant 1 after reset.
- Horizontal phase FSM, advanced only on `pix_en`: H_ACT → H_FP → H_SYNC → H_BP → H_ACT. Each transition occurs when the in-phase counter reaches that phase's length minus 1.
- `hcount` increments on each `pix_en` and wraps from H_TOTAL-1 to 0. On that wrap, the vertical FSM (V_ACT → V_FP → V_SYNC → V_BP) advances and `vcount` increments. `vcount` wraps from V_TOTAL-1 to 0.
- Sync windows (default values):
  - `hsync` = 0 while hcount ∈ [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1], i.e. [656,751].
  - `vsync` = 0 while vcount ∈ [490,491].
- `video_on` = 1 while hcount < H_ACTIVE and vcount < V_ACTIVE.
- All outputs are registered and mutually aligned: `hsync`, `vsync`, `video_on` and the strobes describe the `hcount`/`vcount` values presented in the same cycle. Decode is computed from the next-state counts and registered together with them.
- `line_start` pulses in the clk cycle where `hcount` transitions to 0. `frame_start` pulses when `hcount` and `vcount` transition to 0 together. Neither pulses out of reset.

## Timing
- Reset values: `div`=0, `pix_en`=0, `hcount`=0, `vcount`=0, `hsync`=1, `vsync`=1, `video_on`=0, `line_start`=0, `frame_start`=0. FSMs reset to H_ACT/V_ACT.
- Consequence of reset: pixel (0,0) is blanked for its first period after reset only. From the first wrap onward, `video_on` follows the decode.
- First `pix_en` occurs CLK_DIV clks after `rst` deasserts. Counters update 1 clk after the `pix_en`-qualified edge, i.e. on the edge where `pix_en`=1 is sampled.
- Line period = H_TOTAL·CLK_DIV clks (1600). Frame period = H_TOTAL·V_TOTAL·CLK_DIV clks (840000).
- `rst` asserted mid-frame: the next rising edge forces all reset values regardless of phase. Any in-progress sync pulse is cut short. Counting restarts cleanly.
- Simultaneous end of line and end of frame (hcount=799, vcount=524 on `pix_en`):
  - both counters go to 0 on the same edge;
  - `line_start` and `frame_start` both pulse.

## Structure
- Package `vga_pkg`:
  - `phase_t` enum {ACT, FP, SYNC, BP};
  - 640x480@60 default constants;
  - function computing the total from the four phase lengths.
- Sub-module `vga_axis_counter`, instantiated twice (horizontal and vertical):
  - params: ACTIVE, FRONT, SYNC, BACK;
  - inputs: `clk`, `rst`, `en`;
  - outputs: `count` [9:0], `phase` (phase_t), `wrap` (high when count = total-1 and `en`).
  - The vertical instance's `en` = horizontal `wrap`.
- Top level holds the clock divider, the output decode registers, and the strobe generation.

## Test plan
- Reset: hold `rst` 5 clks → all outputs at reset values. After deassert, first `pix_en` on clk 2, then `hcount`=1 one clk later.
- Line timing: count clks between consecutive `line_start` → 1600.
  - `hsync` low for exactly 96 `pix_en` periods, starting when `hcount`=656.
  - `video_on` low from `hcount`=640 through 799.
- Frame timing: `frame_start` spacing = 840000 clks. `vsync` low for exactly 2 lines (3200 clks), starting when `vcount`=490 and `hcount`=0. `video_on` never high for `vcount` ≥ 480.
- Wrap: at hcount=799, vcount=524 with `pix_en` → next clk hcount=0, vcount=0, `line_start`=1, `frame_start`=1, `video_on`=1.
- Mid-frame reset: pulse `rst` for 1 clk at hcount=700, vcount=491 (both syncs low) → next clk hcount=0, vcount=0, `hsync`=1, `vsync`=1, `video_on`=0.
- CLK_DIV=1 build: `pix_en` constantly 1; line period = 800 clks; frame period = 420000 clks.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared phase type, 640x480@60 default timing constants and axis total helper
package vga_pkg;

    typedef enum logic [1:0] {ACT, FP, SYNC, BP} phase_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FRONT_DEF  = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BACK_DEF   = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF  = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;
    localparam int MAX_TOTAL    = 1024;

    function automatic int axis_total(input int active, input int front, input int sync, input int back);
        return active + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis, position counter plus ACT/FP/SYNC/BP phase FSM
module vga_axis_counter
    import vga_pkg::phase_t, vga_pkg::axis_total, vga_pkg::MAX_TOTAL;
#(
    parameter int ACTIVE = 640,
    parameter int FRONT  = 16,
    parameter int SYNC   = 96,
    parameter int BACK   = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [9:0] count,
    output phase_t     phase,
    output logic       wrap
);

    localparam int TOTAL = axis_total(ACTIVE, FRONT, SYNC, BACK);
    localparam logic [9:0] LAST = 10'(TOTAL - 1);

    if (TOTAL > MAX_TOTAL) begin : g_total_check
        $error("vga_axis_counter: axis total exceeds 1024");
    end

    phase_t     state, state_nxt;
    logic [9:0] pc, len_m1;

    // state register with in-phase and position counters, advancing only on en
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= vga_pkg::ACT;
            pc    <= '0;
            count <= '0;
        end else if (en) begin
            state <= state_nxt;
            pc    <= (pc == len_m1) ? '0 : pc + 10'd1;
            count <= wrap ? '0 : count + 10'd1;
        end
    end

    // next phase once the in-phase counter reaches the current phase length minus 1
    always_comb begin
        len_m1    = (state == vga_pkg::ACT) ? 10'(ACTIVE - 1) :
                    (state == vga_pkg::FP)  ? 10'(FRONT - 1)  :
                    (state == vga_pkg::BP)  ? 10'(BACK - 1)   : 10'(SYNC - 1);
        state_nxt = (pc == len_m1) ? phase_t'(state + 2'd1) : state;
    end

    // phase and end-of-axis outputs
    always_comb begin
        phase = state;
        wrap  = en && (count == LAST);
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing with pixel-enable divider, registered sync/blank decode and line/frame strobes
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FRONT  = H_FRONT_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FRONT  = V_FRONT_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF,
    parameter int CLK_DIV  = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       line_start,
    output logic       frame_start
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam int HS_BEG = H_ACTIVE + H_FRONT;
    localparam int HS_END = HS_BEG + H_SYNC;
    localparam int VS_BEG = V_ACTIVE + V_FRONT;
    localparam int VS_END = VS_BEG + V_SYNC;

    if (CLK_DIV < 1) begin : g_div_check
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end

    logic [DW-1:0] div;
    logic [9:0]    h_nxt, v_nxt;
    logic          h_wrap, v_wrap;
    phase_t        h_phase, v_phase;
    logic          phase_unused;

    assign phase_unused = ^{h_phase, v_phase};

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
    ) u_h (
        .clk(clk), .rst(rst), .en(pix_en),
        .count(hcount), .phase(h_phase), .wrap(h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
    ) u_v (
        .clk(clk), .rst(rst), .en(h_wrap),
        .count(vcount), .phase(v_phase), .wrap(v_wrap)
    );

    // counts as they will be after the next pixel-enabled edge
    assign h_nxt = h_wrap ? '0 : hcount + 10'd1;
    assign v_nxt = v_wrap ? '0 : (h_wrap ? vcount + 10'd1 : vcount);

    // clock divider producing a registered one-clk pixel enable
    always_ff @(posedge clk) begin
        if (rst) begin
            div    <= '0;
            pix_en <= 1'b0;
        end else begin
            div    <= (div == DIV_LAST) ? '0 : div + 1'b1;
            pix_en <= (div == DIV_LAST);
        end
    end

    // decode from next-state counts so outputs land on the same edge as the counts they describe
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= h_wrap;
            frame_start <= v_wrap;
            if (pix_en) begin
                hsync    <= !(int'(h_nxt) >= HS_BEG && int'(h_nxt) < HS_END);
                vsync    <= !(int'(v_nxt) >= VS_BEG && int'(v_nxt) < VS_END);
                video_on <= (int'(h_nxt) < H_ACTIVE) && (int'(v_nxt) < V_ACTIVE);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of reset, line, frame, wrap and mid-frame reset timing
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // a_: default 640x480, CLK_DIV=2
    logic       a_pe, a_hs, a_vs, a_vo, a_ls, a_fs;
    logic [9:0] a_hc, a_vc;
    // b_: default horizontal, 9-line frame, CLK_DIV=1
    logic       b_pe, b_hs, b_vs, b_vo, b_ls, b_fs;
    logic [9:0] b_hc, b_vc;
    // c_: 16x9 raster, CLK_DIV=2
    logic       c_pe, c_hs, c_vs, c_vo, c_ls, c_fs;
    logic [9:0] c_hc, c_vc;

    vga_timing_gen u_a (
        .clk(clk), .rst(rst), .pix_en(a_pe), .hcount(a_hc), .vcount(a_vc),
        .hsync(a_hs), .vsync(a_vs), .video_on(a_vo), .line_start(a_ls), .frame_start(a_fs)
    );

    vga_timing_gen #(
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .CLK_DIV(1)
    ) u_b (
        .clk(clk), .rst(rst), .pix_en(b_pe), .hcount(b_hc), .vcount(b_vc),
        .hsync(b_hs), .vsync(b_vs), .video_on(b_vo), .line_start(b_ls), .frame_start(b_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .CLK_DIV(2)
    ) u_c (
        .clk(clk), .rst(rst), .pix_en(c_pe), .hcount(c_hc), .vcount(c_vc),
        .hsync(c_hs), .vsync(c_vs), .video_on(c_vo), .line_start(c_ls), .frame_start(c_fs)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        int n, hs_low, hs_first, hs_last, vo_bad, vo_hi, pe_low, ls_cnt, ls_first, vs_low, vs_v, vs_h;
        repeat (5) @(negedge clk);
        check("rst_pix_en", a_pe, 0);
        check("rst_hcount", a_hc, 0);
        check("rst_vcount", a_vc, 0);
        check("rst_hsync", a_hs, 1);
        check("rst_vsync", a_vs, 1);
        check("rst_video_on", a_vo, 0);
        check("rst_line_start", a_ls, 0);
        check("rst_frame_start", a_fs, 0);
        rst = 1'b0;
        @(negedge clk);
        check("clk1_pix_en", a_pe, 0);
        check("div1_clk1_pix_en", b_pe, 1);
        @(negedge clk);
        check("clk2_pix_en", a_pe, 1);
        check("clk2_hcount", a_hc, 0);
        check("clk2_video_on", a_vo, 0);
        check("div1_clk2_hcount", b_hc, 1);
        @(negedge clk);
        check("clk3_hcount", a_hc, 1);
        check("clk3_pix_en", a_pe, 0);
        check("clk3_video_on", a_vo, 1);
        check("clk3_line_start", a_ls, 0);

        n = 0;
        while (!a_ls && n < 2000) begin @(negedge clk); n++; end
        check("line_start_seen", a_ls, 1);
        n = 0; hs_low = 0; hs_first = -1; hs_last = -1; vo_bad = 0; vo_hi = 0;
        do begin
            @(negedge clk); n++;
            if (!a_hs) begin hs_low++; if (hs_first < 0) hs_first = int'(a_hc); hs_last = int'(a_hc); end
            if (a_vo !== (a_hc < 10'd640)) vo_bad++;
            if (a_vo) vo_hi++;
        end while (!a_ls && n < 2000);
        check("line_period", n, 1600);
        check("hsync_low_clks", hs_low, 192);
        check("hsync_first_h", hs_first, 656);
        check("hsync_last_h", hs_last, 751);
        check("video_on_decode_bad", vo_bad, 0);
        check("video_on_high_clks", vo_hi, 1280);

        n = 0;
        while (!b_fs && n < 8000) begin @(negedge clk); n++; end
        check("div1_frame_seen", b_fs, 1);
        n = 0; pe_low = 0; ls_cnt = 0; ls_first = -1;
        do begin
            @(negedge clk); n++;
            if (!b_pe) pe_low++;
            if (b_ls) begin ls_cnt++; if (ls_first < 0) ls_first = n; end
        end while (!b_fs && n < 8000);
        check("div1_frame_period", n, 7200);
        check("div1_line_period", ls_first, 800);
        check("div1_lines_per_frame", ls_cnt, 9);
        check("div1_pix_en_low", pe_low, 0);

        n = 0;
        while (!c_fs && n < 400) begin @(negedge clk); n++; end
        check("small_frame_seen", c_fs, 1);
        n = 0; vs_low = 0; vs_v = -1; vs_h = -1; vo_bad = 0;
        do begin
            @(negedge clk); n++;
            if (!c_vs) begin vs_low++; if (vs_v < 0) begin vs_v = int'(c_vc); vs_h = int'(c_hc); end end
            if (c_vo && c_vc >= 10'd4) vo_bad++;
        end while (!c_fs && n < 400);
        check("small_frame_period", n, 288);
        check("vsync_low_clks", vs_low, 64);
        check("vsync_first_v", vs_v, 5);
        check("vsync_first_h", vs_h, 0);
        check("video_on_vblank_bad", vo_bad, 0);

        n = 0;
        while (!(c_hc == 10'd15 && c_vc == 10'd8 && c_pe) && n < 400) begin @(negedge clk); n++; end
        check("wrap_point_seen", (c_hc == 10'd15 && c_vc == 10'd8 && c_pe), 1);
        @(negedge clk);
        check("wrap_hcount", c_hc, 0);
        check("wrap_vcount", c_vc, 0);
        check("wrap_line_start", c_ls, 1);
        check("wrap_frame_start", c_fs, 1);
        check("wrap_video_on", c_vo, 1);

        n = 0;
        while (!(c_hc == 10'd11 && c_vc == 10'd5) && n < 400) begin @(negedge clk); n++; end
        check("midrst_point_seen", (c_hc == 10'd11 && c_vc == 10'd5), 1);
        check("midrst_pre_hsync", c_hs, 0);
        check("midrst_pre_vsync", c_vs, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_hcount", c_hc, 0);
        check("midrst_vcount", c_vc, 0);
        check("midrst_hsync", c_hs, 1);
        check("midrst_vsync", c_vs, 1);
        check("midrst_video_on", c_vo, 0);
        check("midrst_line_start", c_ls, 0);
        repeat (2) @(negedge clk);
        check("midrst_restart_pix_en", c_pe, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
